// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align - load/store alignment unit between execute and data memory.
//
// Takes one load or store per req handshake, drives a word-aligned memory
// port with byte strobes and returns a sign/zero-extended load result.
// Accesses that straddle a word boundary are either issued as two memory
// transactions (MISALIGN_SPLIT = 1) or faulted without touching memory.
//
// Parameters
//   XLEN            data/address width, 32 or 64 (B = XLEN/8 bytes per word)
//   MISALIGN_SPLIT  1: split word-crossing accesses, 0: fault them
//
// Ports
//   clk, reset_n                       clock (rising edge), async active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_we, req_funct3                 store flag, RISC-V size/sign code
//   req_addr, req_wdata, req_rd        byte address, right-justified data, tag
//   mem_valid/mem_ready                memory request handshake
//   mem_we, mem_addr, mem_wdata,       word-aligned request with lane-placed
//   mem_wstrb                          data and byte strobes
//   mem_rvalid, mem_rdata              memory read return
//   rsp_valid, rsp_data, rsp_rd,       one-cycle response pulse with load data,
//   rsp_fault                          echoed tag and fault flag
// -----------------------------------------------------------------------------
module lsu_align #(
   parameter int XLEN           = 32,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_data,
   output logic [4:0]        rsp_rd,
   output logic              rsp_fault
);

   localparam int B  = XLEN / 8;
   localparam int OW = $clog2(B);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ1  = 3'd1,
      WAIT1 = 3'd2,
      REQ2  = 3'd3,
      WAIT2 = 3'd4,
      RESP  = 3'd5
   } state_t;

   state_t state, state_next;

   // Whether funct3 names a legal access for this direction and width.
   function automatic logic code_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b011:                 ok = (XLEN == 64);
         3'b100, 3'b101:         ok = ~we;
         3'b110:                 ok = ~we & (XLEN == 64);
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Sign- or zero-extend the low 8<<f3[1:0] bits of raw to XLEN bits.
   function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                   input logic [2:0]      f3);
      logic [XLEN-1:0] res;
      logic            top;
      int              nbits;
      nbits = 8 << f3[1:0];
      top   = 1'b0;
      for (int i = 0; i < XLEN; i++) begin
         if (i == nbits - 1) top = raw[i];
      end
      top = top & ~f3[2];
      for (int i = 0; i < XLEN; i++) begin
         res[i] = (i < nbits) ? raw[i] : top;
      end
      return res;
   endfunction

   // ---- request decode (combinational, from the request port) ----
   logic legal_in, cross_in, fault_in, split_in;

   always_comb begin
      legal_in = code_legal(req_we, req_funct3);
      cross_in = (int'(req_addr[OW-1:0]) + (1 << req_funct3[1:0])) > B;
      fault_in = ~legal_in | (cross_in & ~MISALIGN_SPLIT);
      split_in = legal_in & cross_in & MISALIGN_SPLIT;
   end

   // ---- stage 1: captured request (data registers, no reset) ----
   logic            we_p1;
   logic [2:0]      f3_p1;
   logic [XLEN-1:0] addr_p1;
   logic [XLEN-1:0] wdata_p1;
   logic [4:0]      rd_p1;
   logic [XLEN-1:0] rdata_lo_p2;
   logic [XLEN-1:0] rdata_hi_p2;

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         we_p1    <= req_we;
         f3_p1    <= req_funct3;
         addr_p1  <= req_addr;
         wdata_p1 <= req_wdata;
         rd_p1    <= req_rd;
      end
      if (state == WAIT1 && mem_rvalid) rdata_lo_p2 <= mem_rdata;
      if (state == WAIT2 && mem_rvalid) rdata_hi_p2 <= mem_rdata;
   end

   // ---- control registers ----
   logic fault_p1, split_p1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         fault_p1 <= 1'b0;
         split_p1 <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && req_valid) begin
            fault_p1 <= fault_in;
            split_p1 <= split_in;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (req_valid) state_next = fault_in ? RESP : REQ1;
         REQ1:  if (mem_ready) begin
                   if (!we_p1)       state_next = WAIT1;
                   else if (split_p1) state_next = REQ2;
                   else               state_next = RESP;
                end
         WAIT1: if (mem_rvalid) state_next = split_p1 ? REQ2 : RESP;
         REQ2:  if (mem_ready) state_next = we_p1 ? RESP : WAIT2;
         WAIT2: if (mem_rvalid) state_next = RESP;
         RESP:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---- stage 2: lane placement and load assembly ----
   int              off_i;
   int              nbytes;
   logic [XLEN-1:0] addr1, addr2;
   logic [B-1:0]    strb1, strb2;
   logic [XLEN-1:0] wdata1, wdata2;
   logic [XLEN-1:0] raw;
   logic [XLEN-1:0] load_data;

   always_comb begin
      off_i  = int'(addr_p1[OW-1:0]);
      nbytes = 1 << f3_p1[1:0];
      addr1  = {addr_p1[XLEN-1:OW], {OW{1'b0}}};
      addr2  = addr1 + XLEN'(B);
      strb1  = '0;
      strb2  = '0;
      wdata1 = '0;
      wdata2 = '0;
      raw    = '0;
      for (int j = 0; j < B; j++) begin
         // Part 1 holds source bytes 0.. starting at lane off_i; part 2 holds
         // whatever spilled past the top lane, starting at lane 0.
         if (j >= off_i && (j - off_i) < nbytes) begin
            strb1[j]          = 1'b1;
            wdata1[8*j +: 8]  = wdata_p1[8*(j - off_i) +: 8];
         end
         if ((j + B - off_i) < nbytes) begin
            strb2[j]          = 1'b1;
            wdata2[8*j +: 8]  = wdata_p1[8*(j + B - off_i) +: 8];
         end
         // Result byte j comes from lane off_i+j of part 1, or wraps into
         // part 2; bytes above the access size are discarded by extension.
         if (off_i + j < B) raw[8*j +: 8] = rdata_lo_p2[8*(off_i + j) +: 8];
         else               raw[8*j +: 8] = rdata_hi_p2[8*(off_i + j - B) +: 8];
      end
      load_data = extend_load(raw, f3_p1);
   end

   // ---- outputs: gated by state so everything idles at zero ----
   always_comb begin
      req_ready = (state == IDLE);
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_rd    = '0;
      rsp_fault = 1'b0;
      case (state)
         REQ1: begin
            mem_valid = 1'b1;
            mem_we    = we_p1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_wstrb = strb1;
         end
         REQ2: begin
            mem_valid = 1'b1;
            mem_we    = we_p1;
            mem_addr  = addr2;
            mem_wdata = wdata2;
            mem_wstrb = strb2;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rd    = rd_p1;
            rsp_fault = fault_p1;
            if (!we_p1 && !fault_p1) rsp_data = load_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        use_b;

   logic        a_req_valid, b_req_valid;
   logic        a_req_ready, b_req_ready;
   logic        a_mem_valid, b_mem_valid;
   logic        a_mem_we, b_mem_we;
   logic [31:0] a_mem_addr, b_mem_addr;
   logic [31:0] a_mem_wdata, b_mem_wdata;
   logic [3:0]  a_mem_wstrb, b_mem_wstrb;
   logic        a_rsp_valid, b_rsp_valid;
   logic [31:0] a_rsp_data, b_rsp_data;
   logic [4:0]  a_rsp_rd, b_rsp_rd;
   logic        a_rsp_fault, b_rsp_fault;

   assign a_req_valid = req_valid & ~use_b;
   assign b_req_valid = req_valid & use_b;

   lsu_align #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd),
      .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_we(a_mem_we),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_rd(a_rsp_rd),
      .rsp_fault(a_rsp_fault)
   );

   lsu_align #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd),
      .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_we(b_mem_we),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_rd(b_rsp_rd),
      .rsp_fault(b_rsp_fault)
   );

   logic        o_req_ready, o_mem_valid, o_mem_we, o_rsp_valid, o_rsp_fault;
   logic [31:0] o_mem_addr, o_mem_wdata, o_rsp_data;
   logic [3:0]  o_mem_wstrb;
   logic [4:0]  o_rsp_rd;

   assign o_req_ready = use_b ? b_req_ready : a_req_ready;
   assign o_mem_valid = use_b ? b_mem_valid : a_mem_valid;
   assign o_mem_we    = use_b ? b_mem_we    : a_mem_we;
   assign o_mem_addr  = use_b ? b_mem_addr  : a_mem_addr;
   assign o_mem_wdata = use_b ? b_mem_wdata : a_mem_wdata;
   assign o_mem_wstrb = use_b ? b_mem_wstrb : a_mem_wstrb;
   assign o_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
   assign o_rsp_data  = use_b ? b_rsp_data  : a_rsp_data;
   assign o_rsp_rd    = use_b ? b_rsp_rd    : a_rsp_rd;
   assign o_rsp_fault = use_b ? b_rsp_fault : a_rsp_fault;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        use_b;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [4:0]  rd;
      int          nparts;
      logic [31:0] a1;
      logic [3:0]  s1;
      logic [31:0] w1;
      logic [31:0] a2;
      logic [3:0]  s2;
      logic [31:0] w2;
      logic [31:0] data;
      logic        fault;
      int          lat;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs[NVEC];

   int total;
   int bad;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc;
      int parts;
      bit pend;
      bit got;
      use_b = v.use_b;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_rd     = v.rd;
      cyc = 0; parts = 0; pend = 1'b0; got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         req_valid  = 1'b0;
         mem_rvalid = pend;
         mem_rdata  = pend ? ((parts == 1) ? v.rd1 : v.rd2) : 32'h0;
         pend = 1'b0;
         if (o_mem_valid) begin
            parts++;
            chk($sformatf("v%0d mem_we", idx), o_mem_we, v.we);
            if (parts == 1) begin
               chk($sformatf("v%0d addr1", idx), o_mem_addr, v.a1);
               chk($sformatf("v%0d strb1", idx), o_mem_wstrb, v.s1);
               if (v.we) chk($sformatf("v%0d wdata1", idx), o_mem_wdata, v.w1);
            end else begin
               chk($sformatf("v%0d addr2", idx), o_mem_addr, v.a2);
               chk($sformatf("v%0d strb2", idx), o_mem_wstrb, v.s2);
               if (v.we) chk($sformatf("v%0d wdata2", idx), o_mem_wdata, v.w2);
            end
            if (!v.we) pend = 1'b1;
         end
         if (o_rsp_valid) begin
            got = 1'b1;
            chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.lat));
            chk($sformatf("v%0d rsp_data", idx), o_rsp_data, v.data);
            chk($sformatf("v%0d rsp_fault", idx), o_rsp_fault, v.fault);
            chk($sformatf("v%0d rsp_rd", idx), o_rsp_rd, v.rd);
         end
      end
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL v%0d timeout: got no response want response by cycle %0d", idx, v.lat);
      end
      chk($sformatf("v%0d mem parts", idx), 64'(parts), 64'(v.nparts));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0; bad = 0;
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0; use_b = 1'b0;

      //           use_b we    f3      addr          wdata         rd1           rd2           rd   np a1            s1       w1            a2            s2       w2            data          fault lat
      vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1003, 32'h0,       32'h80FF_0000, 32'h0,       5'd1, 1, 32'h0000_1000, 4'b1000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'hFFFF_FF80, 1'b0, 3};
      vecs[1]  = '{1'b0, 1'b0, 3'b100, 32'h0000_1003, 32'h0,       32'h80FF_0000, 32'h0,       5'd2, 1, 32'h0000_1000, 4'b1000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'h0000_0080, 1'b0, 3};
      vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0,       32'h0,       5'd3, 1, 32'h0000_2000, 4'b1100, 32'hBEEF_0000, 32'h0,      4'b0000, 32'h0,       32'h0,         1'b0, 2};
      vecs[3]  = '{1'b0, 1'b0, 3'b010, 32'h0000_3001, 32'h0,       32'hDDCC_BBAA, 32'h4433_2211, 5'd4, 2, 32'h0000_3000, 4'b1110, 32'h0,     32'h0000_3004, 4'b0001, 32'h0,       32'h11DD_CCBB, 1'b0, 5};
      vecs[4]  = '{1'b1 ^ 1'b1, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1234_5678, 32'h0, 32'h0,       5'd5, 2, 32'hFFFF_FFFC, 4'b1100, 32'h5678_0000, 32'h0000_0000, 4'b0011, 32'h0000_1234, 32'h0,   1'b0, 3};
      vecs[5]  = '{1'b0, 1'b0, 3'b001, 32'h0000_1006, 32'h0,       32'h8001_0000, 32'h0,       5'd6, 1, 32'h0000_1004, 4'b1100, 32'h0,       32'h0,       4'b0000, 32'h0,       32'hFFFF_8001, 1'b0, 3};
      vecs[6]  = '{1'b0, 1'b0, 3'b101, 32'h0000_1007, 32'h0,       32'hAB00_0000, 32'h0000_00CD, 5'd7, 2, 32'h0000_1004, 4'b1000, 32'h0,     32'h0000_1008, 4'b0001, 32'h0,       32'h0000_CDAB, 1'b0, 5};
      vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_4001, 32'hFFFF_FF5A, 32'h0,       32'h0,       5'd8, 1, 32'h0000_4000, 4'b0010, 32'h0000_5A00, 32'h0,      4'b0000, 32'h0,       32'h0,         1'b0, 2};
      vecs[8]  = '{1'b0, 1'b0, 3'b010, 32'h0000_5000, 32'h0,       32'hCAFE_F00D, 32'h0,       5'd9, 1, 32'h0000_5000, 4'b1111, 32'h0,       32'h0,       4'b0000, 32'h0,       32'hCAFE_F00D, 1'b0, 3};
      vecs[9]  = '{1'b0, 1'b0, 3'b011, 32'h0000_5000, 32'h0,       32'h0,        32'h0,        5'd10, 0, 32'h0,        4'b0000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'h0,         1'b1, 1};
      vecs[10] = '{1'b0, 1'b0, 3'b111, 32'h0000_5000, 32'h0,       32'h0,        32'h0,        5'd11, 0, 32'h0,        4'b0000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'h0,         1'b1, 1};
      vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0000_5000, 32'h0000_0011, 32'h0,      32'h0,        5'd12, 0, 32'h0,        4'b0000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'h0,         1'b1, 1};
      vecs[12] = '{1'b0, 1'b0, 3'b110, 32'h0000_5000, 32'h0,       32'h0,        32'h0,        5'd13, 0, 32'h0,        4'b0000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'h0,         1'b1, 1};
      vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,       32'hDDCC_BBAA, 32'h4433_2211, 5'd14, 0, 32'h0,      4'b0000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'h0,         1'b1, 1};
      vecs[14] = '{1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0,       32'h0,        32'h0,        5'd15, 0, 32'h0,        4'b0000, 32'h0,       32'h0,       4'b0000, 32'h0,       32'h0,         1'b1, 1};
      vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0,       32'h0BAD_CAFE, 32'h0,       5'd16, 1, 32'h0000_3000, 4'b1111, 32'h0,     32'h0,       4'b0000, 32'h0,       32'h0BAD_CAFE, 1'b0, 3};
      vecs[16] = '{1'b1, 1'b0, 3'b000, 32'h0000_3003, 32'h0,       32'h7F00_0000, 32'h0,       5'd17, 1, 32'h0000_3000, 4'b1000, 32'h0,     32'h0,       4'b0000, 32'h0,       32'h0000_007F, 1'b0, 3};

      // Reset state of both instances.
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         use_b = (u == 1);
         #1;
         chk($sformatf("rst%0d req_ready", u), o_req_ready, 1'b1);
         chk($sformatf("rst%0d mem_valid", u), o_mem_valid, 1'b0);
         chk($sformatf("rst%0d mem_bus", u),
             {o_mem_we, o_mem_wstrb, o_mem_addr}, 37'h0);
         chk($sformatf("rst%0d mem_wdata", u), o_mem_wdata, 32'h0);
         chk($sformatf("rst%0d rsp", u),
             {o_rsp_valid, o_rsp_fault, o_rsp_rd, o_rsp_data}, 39'h0);
      end
      use_b = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);
      use_b = 1'b0;

      // mem_ready low for three cycles: the request must hold steady.
      @(negedge clk);
      mem_ready  = 1'b0;
      req_valid  = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr   = 32'h0000_6000; req_wdata = 32'hA5A5_A5A5; req_rd = 5'd20;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         chk($sformatf("stall c%0d mem_valid", c), o_mem_valid, 1'b1);
         chk($sformatf("stall c%0d addr", c), o_mem_addr, 32'h0000_6000);
         chk($sformatf("stall c%0d wdata", c), o_mem_wdata, 32'hA5A5_A5A5);
         chk($sformatf("stall c%0d strb", c), o_mem_wstrb, 4'b1111);
         chk($sformatf("stall c%0d rsp_valid", c), o_rsp_valid, 1'b0);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("stall rsp_valid", o_rsp_valid, 1'b1);
      chk("stall rsp_rd", o_rsp_rd, 5'd20);
      chk("stall rsp_data", o_rsp_data, 32'h0);

      // Reset during WAIT1 abandons the load.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
      req_addr  = 32'h0000_7000; req_wdata = 32'h0; req_rd = 5'd21;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid REQ1 mem_valid", o_mem_valid, 1'b1);
      @(negedge clk);
      chk("rstmid WAIT1 req_ready", o_req_ready, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("rstmid async mem_valid", o_mem_valid, 1'b0);
      chk("rstmid async rsp_valid", o_rsp_valid, 1'b0);
      chk("rstmid async req_ready", o_req_ready, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rstmid after c%0d rsp_valid", c), o_rsp_valid, 1'b0);
         chk($sformatf("rstmid after c%0d mem_valid", c), o_mem_valid, 1'b0);
         chk($sformatf("rstmid after c%0d req_ready", c), o_req_ready, 1'b1);
      end

      // Unit is usable again after the abandoned access.
      run_vec(100, vecs[3]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
